simd_alu_issue: RTL and testbench

SIMD_ALU_ISSUE -- requirements
Module: simd_alu_issue

---
 rtl/simd_alu_issue.sv | 166 ++++++++++++++++
 tb/tb_simd_alu_issue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_issue.sv
// simd_alu_issue: issues one command to simd_alu_top and captures its result.
// `define SIMD_ALU_ISSUE_OVF_EN to add the per-lane signed overflow output res_ovf.
package simd_alu_issue_pkg;
  localparam int unsigned OPC_NOP     = 0;
  localparam int unsigned OPC_ADD8    = 1;
  localparam int unsigned OPC_S_ADD8  = 2;
  localparam int unsigned OPC_ADD16   = 3;
  localparam int unsigned OPC_S_ADD16 = 4;
endpackage

module simd_alu_issue
  import simd_alu_issue_pkg::*;
#(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int SIMD_OPC_WIDTH  = 4,
  parameter int ALU_LATENCY     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [SIMD_OPC_WIDTH-1:0]  cmd_opcode,
  input  logic [SIMD_DATA_WIDTH-1:0] cmd_a,
  input  logic [SIMD_DATA_WIDTH-1:0] cmd_b,
  output logic [SIMD_DATA_WIDTH-1:0] alu_a,
  output logic [SIMD_DATA_WIDTH-1:0] alu_b,
  output logic [SIMD_OPC_WIDTH-1:0]  alu_opcode,
  input  logic [SIMD_DATA_WIDTH-1:0] alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SIMD_DATA_WIDTH-1:0] res_data,
  output logic                       res_err
`ifdef SIMD_ALU_ISSUE_OVF_EN
  ,
  output logic [SIMD_DATA_WIDTH/8-1:0] res_ovf
`endif
);

  localparam int W  = SIMD_DATA_WIDTH;
  localparam int OW = SIMD_OPC_WIDTH;

  localparam logic [OW-1:0] OP_NOP     = OW'(OPC_NOP);
  localparam logic [OW-1:0] OP_ADD8    = OW'(OPC_ADD8);
  localparam logic [OW-1:0] OP_S_ADD8  = OW'(OPC_S_ADD8);
  localparam logic [OW-1:0] OP_ADD16   = OW'(OPC_ADD16);
  localparam logic [OW-1:0] OP_S_ADD16 = OW'(OPC_S_ADD16);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [OW-1:0] opc_q;
  logic          bad_q;
  logic [3:0]    cnt;
  logic          opc_ok;

  assign cmd_ready = (state == S_IDLE) |
                     ((state == S_HOLD) & res_ready);

  // ALU sees the command only during ISSUE; bad opcodes go out as NOP
  assign alu_a      = (state == S_ISSUE) ? a_q : '0;
  assign alu_b      = (state == S_ISSUE) ? b_q : '0;
  assign alu_opcode = (state == S_ISSUE && !bad_q) ? opc_q : OP_NOP;

  // Decode which incoming opcodes the ALU supports
  always_comb begin
    opc_ok = 1'b0;
    unique case (cmd_opcode)
      OP_NOP, OP_ADD8, OP_S_ADD8,
      OP_ADD16, OP_S_ADD16: opc_ok = 1'b1;
      default:              opc_ok = 1'b0;
    endcase
  end

`ifdef SIMD_ALU_ISSUE_OVF_EN
  localparam int NB = W / 8;
  localparam int NH = W / 16;

  logic [NB-1:0] ovf_nxt;

  // Signed overflow: operand signs agree, result sign differs
  always_comb begin
    ovf_nxt = '0;
    if (opc_q == OP_S_ADD8) begin
      for (int i = 0; i < NB; i++) begin
        ovf_nxt[i] = (a_q[8*i+7] == b_q[8*i+7]) &
                     (alu_out[8*i+7] != a_q[8*i+7]);
      end
    end else if (opc_q == OP_S_ADD16) begin
      for (int i = 0; i < NH; i++) begin
        ovf_nxt[i] = (a_q[16*i+15] == b_q[16*i+15]) &
                     (alu_out[16*i+15] != a_q[16*i+15]);
      end
    end
  end
`endif

  // Issue FSM: accept, issue one cycle, wait latency, hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      opc_q     <= '0;
      bad_q     <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
`ifdef SIMD_ALU_ISSUE_OVF_EN
      res_ovf   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            a_q   <= cmd_a;
            b_q   <= cmd_b;
            opc_q <= cmd_opcode;
            bad_q <= !opc_ok;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= 4'(ALU_LATENCY - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            res_valid <= 1'b1;
            res_data  <= bad_q ? '0 : alu_out;
            res_err   <= bad_q;
`ifdef SIMD_ALU_ISSUE_OVF_EN
            res_ovf   <= bad_q ? '0 : ovf_nxt;
`endif
            state     <= S_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (cmd_valid) begin
              a_q   <= cmd_a;
              b_q   <= cmd_b;
              opc_q <= cmd_opcode;
              bad_q <= !opc_ok;
              state <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_alu_issue.sv
// tb_simd_alu_issue: vector table plus hand sequences against a
// behavioural one-cycle simd_alu_top model and a result scoreboard.
module tb_simd_alu_issue;
  import simd_alu_issue_pkg::*;

  localparam int W  = 256;
  localparam int NB = W / 8;
  localparam int NH = W / 16;

  localparam logic [3:0] NOP     = 4'(OPC_NOP);
  localparam logic [3:0] ADD8    = 4'(OPC_ADD8);
  localparam logic [3:0] S_ADD8  = 4'(OPC_S_ADD8);
  localparam logic [3:0] ADD16   = 4'(OPC_ADD16);
  localparam logic [3:0] S_ADD16 = 4'(OPC_S_ADD16);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_out = '0;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_err;
`ifdef SIMD_ALU_ISSUE_OVF_EN
  logic [NB-1:0] res_ovf;
`endif

  simd_alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err)
`ifdef SIMD_ALU_ISSUE_OVF_EN
    ,
    .res_ovf    (res_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural simd_alu_top: NOP passes in_a, unknown codes give all ones
  function automatic logic [W-1:0] alu_f(logic [3:0] op,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    logic [W-1:0] r;
    r = '1;
    case (op)
      NOP: r = a;
      ADD8, S_ADD8:
        for (int i = 0; i < NB; i++)
          r[8*i+:8] = a[8*i+:8] + b[8*i+:8];
      ADD16, S_ADD16:
        for (int i = 0; i < NH; i++)
          r[16*i+:16] = a[16*i+:16] + b[16*i+:16];
      default: r = '1;
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  d;
    logic          e;
    logic [NB-1:0] o;
  } vec_t;

  typedef struct {
    logic [W-1:0]  d;
    logic          e;
    logic [NB-1:0] o;
    int            t;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_new = 0;
  int   prev_new = 0;
  logic pv = 1'b0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Result monitor: compares the scoreboard head while res_valid is up
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      #3;
      if (rst) begin
        pv = 1'b0;
      end else if (res_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_res: res_valid=1 got, none outstanding");
        end else begin
          if (!pv) begin
            chk("latency", W'(cyc - sb[0].t), W'(2));
            prev_new = last_new;
            last_new = cyc;
          end
          chk("res_data", res_data, sb[0].d);
          chk("res_err", W'(res_err), W'(sb[0].e));
`ifdef SIMD_ALU_ISSUE_OVF_EN
          chk("res_ovf", W'(res_ovf), W'(sb[0].o));
`endif
          if (res_ready) void'(sb.pop_front());
        end
        pv = 1'b1;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic send(vec_t v);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cmd_opcode = v.op;
    cmd_a      = v.a;
    cmd_b      = v.b;
    cmd_valid  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", W'(ok), W'(1));
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{d: v.d, e: v.e, o: v.o, t: cyc + 1});
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'hF;
    cmd_a      = '1;
    cmd_b      = '1;
    @(negedge clk);
    #1;
    chk("issue_opc", W'(alu_opcode), W'(v.e ? NOP : v.op));
    chk("issue_a", alu_a, v.a);
    chk("issue_b", alu_b, v.b);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    chk("drain", W'(sb.size()), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  a8, b8, a16, b16, an, bn, held;
    logic [NB-1:0] ov16;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    res_ready  = 1'b1;
    ov16       = '0;
    ov16[NH-1:0] = '1;
    for (int i = 0; i < NB; i++) begin
      a8[8*i+:8] = 8'(i);
      b8[8*i+:8] = 8'(32 - i);
    end
    for (int i = 0; i < NH; i++) begin
      a16[16*i+:16] = 16'(i);
      b16[16*i+:16] = 16'(1024 - i);
      an[16*i+:16]  = 16'(-i);
      bn[16*i+:16]  = 16'(-1024 + i);
    end
    tbl[0] = '{ADD8, a8, b8, {NB{8'h20}}, 1'b0, '0};
    tbl[1] = '{S_ADD8, {NB{8'h7F}}, {NB{8'h7F}},
               {NB{8'hFE}}, 1'b0, '1};
    tbl[2] = '{ADD16, a16, b16, {NH{16'd1024}}, 1'b0, '0};
    tbl[3] = '{S_ADD16, {NH{16'h7FFF}}, {NH{16'h0001}},
               {NH{16'h8000}}, 1'b0, ov16};
    tbl[4] = '{NOP, a8, b8, a8, 1'b0, '0};
    tbl[5] = '{4'hF, a8, b8, '0, 1'b1, '0};
    tbl[6] = '{4'h5, {NB{8'h7F}}, {NB{8'h7F}}, '0, 1'b1, '0};
    tbl[7] = '{ADD8, {NB{8'hFF}}, {NB{8'h01}}, '0, 1'b0, '0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_res_data", res_data, '0);
    chk("rst_res_err", W'(res_err), W'(0));
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_opc", W'(alu_opcode), W'(NOP));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", W'(cmd_ready), W'(1));

    foreach (tbl[i]) send(tbl[i]);
    drain();

    // Result held with res_ready low for five cycles
    res_ready = 1'b0;
    send('{S_ADD16, an, bn, {NH{16'hFC00}}, 1'b0, '0});
    for (int k = 0; k < 20 && !res_valid; k++) @(negedge clk);
    #1;
    chk("hold_valid", W'(res_valid), W'(1));
    held = res_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("hold_cmd_ready", W'(cmd_ready), W'(0));
      chk("hold_stable", res_data, held);
    end
    res_ready = 1'b1;
    #1;
    chk("hold_release", W'(cmd_ready), W'(1));
    drain();

    // Back-to-back: second command accepted while first is retired
    send('{ADD16, a16, b16, {NH{16'd1024}}, 1'b0, '0});
    send('{S_ADD16, an, bn, {NH{16'hFC00}}, 1'b0, '0});
    drain();
    chk("b2b_spacing", W'(last_new - prev_new), W'(3));

    // Reset in WAIT discards the command
    send(tbl[0]);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_valid", W'(res_valid), W'(0));
    chk("midrst_alu_a", alu_a, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", W'(cmd_ready), W'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("midrst_quiet", W'(res_valid), W'(0));
    end
    send(tbl[0]);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
